score_cmd_sched: RTL
====================

// Module: score_cmd_sched
// PURPOSE
//  Command scheduler between the button conditioners and the BCD score counter.
//  - Collects one-cycle incr/decr/clr pulses into pending counts.
//  - Arbitrates between them and issues one command at a time on a valid/ready port.
//  - Drops commands that would pass 00 or 99, and enforces a post-clear lockout.
// PARAMETERS
//  SIMULATE      0    1 = use LOCKOUT_SIM instead of LOCKOUT_HW (short sims)
//  PEND_W        4    width of each pending counter; saturates at 2**PEND_W-1
//  LOCKOUT_HW    1_000_000  post-clear lockout in clocks (10 ms at 100 MHz)
//  LOCKOUT_SIM   16   post-clear lockout in clocks when SIMULATE=1
// PORTS
//  clk_100MHz  in   1  system clock; all logic is rising-edge
//  reset       in   1  synchronous, active-high
//  incr_pulse  in   1  conditioned single-cycle increment request
//  decr_pulse  in   1  conditioned single-cycle decrement request
//  clr_pulse   in   1  conditioned single-cycle clear request
//  score_bcd   in   8  current packed BCD score {hi,lo} from the counter
//  cmd_ready   in   1  counter accepts cmd_op this cycle
//  cmd_valid   out  1  cmd_op is valid
//  cmd_op      out  2  score_op_e: NOP=0, INC=1, DEC=2, CLR=3
//  busy        out  1  high in any state except IDLE
//  sat_pulse   out  1  one cycle, marks a pending INC/DEC dropped at 99/00
//  pend_ovf    out  1  sticky; a request arrived while its pending counter was full
// BEHAVIOUR
//  Reset values: state IDLE, cmd_valid 0, cmd_op NOP, busy 0, sat_pulse 0, pend_ovf 0.
//    Both pending counts 0, clr_pend 0, last_op DEC (so INC wins the first tie).
//  Request capture (every state except LOCKOUT):
//    incr/decr pulse adds 1 to its pending count; a pulse at full count sets pend_ovf.
//    clr_pulse sets clr_pend, zeroes both counts, clears pend_ovf.
//      incr/decr pulses in the same cycle are discarded.
//    incr and decr in the same cycle both increment.
//    In LOCKOUT all three pulses are ignored.
//  Pending decrement: on issue, or on drop at saturation.
//  FSM:
//    IDLE:   pick in priority order: clr_pend -> CLR;
//            else both counts >0 -> round-robin against last_op;
//            else the nonzero one.
//            INC with score_bcd==8'h99, or DEC with 8'h00: drop it.
//              Decrement its count, pulse sat_pulse, stay IDLE.
//            Otherwise load cmd_op, assert cmd_valid -> ISSUE.
//    ISSUE:  hold cmd_valid/cmd_op stable until cmd_valid&&cmd_ready at an edge.
//            A CLR arriving here is latched in clr_pend and not preempted.
//            At the handshake: drop cmd_valid, cmd_op=NOP, update last_op.
//              CLR: clear clr_pend -> LOCKOUT.
//              Else: decrement count -> SETTLE.
//    SETTLE: one cycle for score_bcd to update -> IDLE.
//    LOCKOUT: counter loads LOCKOUT_SIM or LOCKOUT_HW on entry, counts down.
//            Returns to IDLE after exactly that many cycles.
//  Latency: pulse sampled at edge k -> pending count updated at k.
//    cmd_valid high after edge k+1 when IDLE.
//    Minimum spacing between accepted INC/DEC is 3 clocks (ISSUE, SETTLE, IDLE).
//  Saturation is judged only in IDLE, against score_bcd after SETTLE.
//  The counter never receives INC at 99 or DEC at 00.
//  reset asserted in any state returns every output to its reset value at the next edge.
//    An in-flight command is abandoned.
// STRUCTURE
//  scoreboard_pkg: score_op_e; BCD_MAX=8'h99; BCD_MIN=8'h00; sched_state_e (IDLE, ISSUE, SETTLE, LOCKOUT).
//  Sub-module pend_counter (PEND_W): saturating up/down counter.
//    Inputs: inc, dec, flush (flush dominates).
//    Outputs: count, nonzero, full.
//    Instantiated twice, for incr and decr.
//  Top module: FSM, arbiter, lockout timer.
// TESTING (SIMULATE=1, cmd_ready tied 1 unless stated)
//  1. Reset, then 10 incr_pulses 5 clocks apart, score starts at 00.
//     -> 10 INC handshakes, score 8'h10, sat_pulse never high.
//  2. Score 8'h02, 5 decr_pulses back-to-back -> 2 DEC issued, 3 sat_pulse, final 8'h00, busy ends 0.
//  3. Pulse incr and decr in the same cycle, 3 times, score at 8'h50.
//     -> issue order INC,DEC,INC,DEC,INC,DEC; final 8'h50.
//  4. cmd_ready held 0 for 20 cycles with INC pending.
//     -> cmd_op stays INC, cmd_valid stays 1 the whole time.
//     clr_pulse mid-wait -> INC completes, then CLR, then score 8'h00.
//  5. 20 incr_pulses while cmd_ready=0 (PEND_W=4) -> pend_ovf=1, at most 15 INCs issued.
//     Then clr_pulse -> pend_ovf=0.
//  6. After a CLR handshake, pulse incr during the 16 LOCKOUT cycles -> no INC issued.
//     Pulse on cycle 17 -> INC issued.
//     Reset mid-ISSUE -> cmd_valid=0 and state IDLE at the next edge.

Source files
------------

// File: rtl/score_cmd_sched_pkg.sv
// Shared types and constants for the score command scheduler.
package score_cmd_sched_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned SCORE_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 2'd0,
        OP_INC = 2'd1,
        OP_DEC = 2'd2,
        OP_CLR = 2'd3
    } score_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_SETTLE  = 2'd2,
        S_LOCKOUT = 2'd3
    } sched_state_e;

    localparam logic [SCORE_W-1:0] BCD_MAX = 8'h99;
    localparam logic [SCORE_W-1:0] BCD_MIN = 8'h00;

    // True when the op would push the counter past 00 or 99.
    function automatic logic is_sat(input score_op_e op, input logic [SCORE_W-1:0] score);
        return ((op == OP_INC) && (score == BCD_MAX)) ||
               ((op == OP_DEC) && (score == BCD_MIN));
    endfunction

endpackage

// File: rtl/score_cmd_sched_pend_counter.sv
// Saturating up/down pending-request counter; flush dominates inc/dec.
module score_cmd_sched_pend_counter #(
    parameter int unsigned PEND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              flush,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              full
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] count_nxt;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (inc && !dec) begin
            if (count != CNT_MAX) count_nxt = count + PEND_W'(1);
        end else if (dec && !inc) begin
            if (count != '0) count_nxt = count - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            nonzero <= 1'b0;
            full    <= 1'b0;
        end else begin
            count   <= count_nxt;
            nonzero <= (count_nxt != '0);
            full    <= (count_nxt == CNT_MAX);
        end
    end

endmodule

// File: rtl/score_cmd_sched.sv
// Collects incr/decr/clr requests, arbitrates them and issues one command at a
// time to the BCD score counter, dropping moves past 00/99 and locking out after clear.
module score_cmd_sched
    import score_cmd_sched_pkg::*;
#(
    parameter bit          SIMULATE    = 1'b0,
    parameter int unsigned PEND_W      = 4,
    parameter int unsigned LOCKOUT_HW  = 1_000_000,
    parameter int unsigned LOCKOUT_SIM = 16
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               incr_pulse,
    input  logic               decr_pulse,
    input  logic               clr_pulse,
    input  logic [SCORE_W-1:0] score_bcd,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output score_op_e          cmd_op,
    output logic               busy,
    output logic               sat_pulse,
    output logic               pend_ovf
);

    localparam int unsigned     LOCKOUT_CYC = SIMULATE ? LOCKOUT_SIM : LOCKOUT_HW;
    localparam int unsigned     LOCK_W      = $clog2(LOCKOUT_CYC + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC);

    sched_state_e      state;
    score_op_e         last_op;
    logic              clr_pend;
    logic [LOCK_W-1:0] lock_cnt;

    logic [PEND_W-1:0] inc_count;
    logic [PEND_W-1:0] dec_count;
    logic              inc_nz;
    logic              dec_nz;
    logic              inc_full;
    logic              dec_full;

    logic      capture_en;
    logic      flush;
    logic      inc_req;
    logic      dec_req;
    logic      handshake;
    logic      idle_drop;
    logic      inc_take;
    logic      dec_take;
    score_op_e pick_op;
    logic      pick_sat;

    // Request capture is frozen during the post-clear lockout.
    always_comb begin
        capture_en = (state != S_LOCKOUT);
        flush      = capture_en && clr_pulse;
        inc_req    = capture_en && incr_pulse && !clr_pulse;
        dec_req    = capture_en && decr_pulse && !clr_pulse;
        handshake  = (state == S_ISSUE) && cmd_valid && cmd_ready;
    end

    // Arbiter: clear first, then round-robin against the last issued op.
    always_comb begin
        pick_op = OP_NOP;
        if (clr_pend) begin
            pick_op = OP_CLR;
        end else if (inc_nz && dec_nz) begin
            pick_op = (last_op == OP_INC) ? OP_DEC : OP_INC;
        end else if (inc_nz) begin
            pick_op = OP_INC;
        end else if (dec_nz) begin
            pick_op = OP_DEC;
        end
        pick_sat  = is_sat(pick_op, score_bcd);
        idle_drop = (state == S_IDLE) && pick_sat;
        inc_take  = (idle_drop && (pick_op == OP_INC)) || (handshake && (cmd_op == OP_INC));
        dec_take  = (idle_drop && (pick_op == OP_DEC)) || (handshake && (cmd_op == OP_DEC));
    end

    score_cmd_sched_pend_counter #(.PEND_W(PEND_W)) u_incr_pend (
        .clk     (clk_100MHz),
        .reset   (reset),
        .inc     (inc_req),
        .dec     (inc_take),
        .flush   (flush),
        .count   (inc_count),
        .nonzero (inc_nz),
        .full    (inc_full)
    );

    score_cmd_sched_pend_counter #(.PEND_W(PEND_W)) u_decr_pend (
        .clk     (clk_100MHz),
        .reset   (reset),
        .inc     (dec_req),
        .dec     (dec_take),
        .flush   (flush),
        .count   (dec_count),
        .nonzero (dec_nz),
        .full    (dec_full)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NOP;
            busy      <= 1'b0;
            sat_pulse <= 1'b0;
            pend_ovf  <= 1'b0;
            clr_pend  <= 1'b0;
            last_op   <= OP_DEC;
            lock_cnt  <= '0;
        end else begin
            sat_pulse <= 1'b0;

            if (flush) begin
                pend_ovf <= 1'b0;
            end else if ((inc_req && inc_full) || (dec_req && dec_full)) begin
                pend_ovf <= 1'b1;
            end

            // A fresh clear request outranks retiring the one being handshaken.
            if (flush) begin
                clr_pend <= 1'b1;
            end else if (handshake && (cmd_op == OP_CLR)) begin
                clr_pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pick_op != OP_NOP) begin
                        if (pick_sat) begin
                            sat_pulse <= 1'b1;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_op    <= pick_op;
                            busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= OP_NOP;
                        last_op   <= cmd_op;
                        if (cmd_op == OP_CLR) begin
                            lock_cnt <= LOCK_LOAD;
                            state    <= S_LOCKOUT;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_LOCKOUT: begin
                    if (lock_cnt <= LOCK_W'(1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_W'(1);
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    cmd_op    <= OP_NOP;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // The registered nonzero flags must always agree with the counts they summarise.
    assert property (@(posedge clk_100MHz) disable iff (reset)
                     (inc_nz == (inc_count != '0)) && (dec_nz == (dec_count != '0)));

endmodule
